seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits, the parametrised successor to the single-digit hex decoder in the Seg7_Dev path. It latches a packed hex word plus per-digit point and blank masks and updates the display only at frame boundaries, so the display never shows a mix of old and new data. It then scans the digits one at a time with a programmable dwell and a one-cycle anode dead time. Sits between the CPU debug/IO bus and the board's segment and anode pins.

## Interface
- DIGITS, 8, number of digits scanned; 1..16
- SCAN_DIV, 1024, clock cycles per digit dwell; ≥2
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle request to capture hex_data/point/blank
- hex_data  in  4*DIGITS  digit k = hex_data[4k+3:4k]; digit 0 is rightmost
- point  in  DIGITS  per-digit decimal point, 1 = lit
- blank  in  DIGITS  per-digit blank, 1 = digit dark including its point
- pending_o  out  1  captured data is waiting for the next frame boundary
- frame_o  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0
- seg_o  out  8  {p,g,f,e,d,c,b,a}, active-low
- an_o  out  DIGITS  digit anode enables, active-low

## Operation
- State: dwell counter cnt (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), pending regs (data/point/blank + pending flag), shadow regs driving the display.
- cnt increments every cycle. At cnt==SCAN_DIV-1 it wraps to 0 and idx advances. idx wraps from DIGITS-1 to 0. That wrap is the frame boundary.
- load captures inputs into the pending regs and sets pending. A second load while pending overwrites the pending data; last capture wins.
- At a frame boundary with pending=1: shadow ← pending regs, pending cleared.
- load on the boundary cycle: the input data goes straight to shadow, and pending ends 0.
- Glyphs, active-low gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- p = ~point[idx].
- Digit blanked → seg_o = 8'hFF.

## Timing
- All outputs registered. They are computed from the cnt, idx and shadow values of the previous cycle.
- an_o = all ones when cnt==0 (dead cycle), else ~(1<<idx). seg_o is valid for idx in that same cycle.
- frame_o asserts in the cycle after the boundary edge, aligned with the first dead cycle of digit 0.
- Latency, load with pending=0 and no boundary: pending_o=1 on the next cycle. New glyphs appear on the first cycle after the next boundary.
- Reset values:
  - Registers: cnt=0, idx=0, pending=0; shadow data=0, point=0, blank=all ones.
  - Outputs: seg_o=8'hFF, an_o=all ones, frame_o=0, pending_o=0.
- Reset mid-scan or mid-pending: pending data is discarded. The scan restarts at digit 0 on the first cycle after rst falls, and that first cycle is a dead cycle.
- Frame period = DIGITS*SCAN_DIV cycles.

## Configuration
- SEG7_LZ_SUPPRESS_EN defined:
  - Working from digit DIGITS-1 downward, each digit that is 0 with its point clear is blanked.
  - Suppression stops at the first nonzero digit or the first digit with its point set.
  - Digit 0 is never suppressed.
  - Applied to shadow data only, in the same cycle as the glyph lookup.
- Undefined: all non-blanked digits are shown, including leading zeros.

## Test plan
- Reset then idle, DIGITS=4, SCAN_DIV=4:
  - seg_o=FF and an_o=F while rst is high.
  - Then an_o cycles F,E,E,E,F,D,D,D,… and seg_o stays FF (all digits blanked).
- Load hex_data=16'h8F10, point=4'b0010, blank=0:
  - pending_o=1 until the boundary; frame_o pulses.
  - Then digit0 seg=C0, digit1 seg=79 (point lit), digit2 seg=8E, digit3 seg=80.
- Two loads before a boundary, 16'h1111 then 16'h2222: only 2222 is displayed (seg=A4 on every digit), with no frame showing 1111.
- Load asserted exactly on the boundary cycle: new data is displayed from digit 0 of that frame, and pending_o is never set.
- Assert rst mid-frame with pending=1: after release, pending_o=0, the display is blank, and the scan starts at digit 0 with a dead cycle.
- With SEG7_LZ_SUPPRESS_EN, hex_data=16'h0050, point=0:
  - Digits 3 and 2 are dark (FF); digit1 seg=92 and digit0 seg=C0.
  - Setting point[3] restores digit 3 as 40.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bus-side bundle for seg7_scan_driver: capture request, data/point/blank masks,
// and the segment/anode pins plus status flags.
interface seg7_scan_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   hex_data;
    logic [DIGITS-1:0]     point;
    logic [DIGITS-1:0]     blank;
    logic                  pending_o;
    logic                  frame_o;
    logic [7:0]            seg_o;
    logic [DIGITS-1:0]     an_o;

    modport master (
        output load, hex_data, point, blank,
        input  pending_o, frame_o, seg_o, an_o
    );

    modport slave (
        input  load, hex_data, point, blank,
        output pending_o, frame_o, seg_o, an_o
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-seg scanner with frame-boundary double buffering.
// Optional leading-zero suppression: define SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    pending;
    logic [DIGITS-1:0][3:0]  pend_data, sh_data;
    logic [DIGITS-1:0]       pend_point, pend_blank, sh_point, sh_blank;
    logic                    wrap_q;
    logic                    frame_q;
    logic [7:0]              seg_q;
    logic [DIGITS-1:0]       an_q;
    logic [DIGITS-1:0]       lz;
    logic                    last_cnt, boundary, dark;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    assign last_cnt = (cnt == CW'(SCAN_DIV - 1));
    assign boundary = last_cnt && (idx == IW'(DIGITS - 1));

`ifdef SEG7_LZ_SUPPRESS_EN
    // Walk down from the top digit; the run of blanked zeros ends at the
    // first nonzero digit or lit point. Digit 0 always stays visible.
    logic lz_run;
    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (sh_data[k] != 4'd0 || sh_point[k])
                lz_run = 1'b0;
            lz[k] = lz_run;
        end
    end
`else
    assign lz = '0;
`endif

    assign dark = sh_blank[idx] | lz[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            pend_data  <= '0;
            pend_point <= '0;
            pend_blank <= '0;
            sh_data    <= '0;
            sh_point   <= '0;
            sh_blank   <= '1;
            wrap_q     <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= 8'hFF;
            an_q       <= '1;
        end else begin
            cnt <= last_cnt ? '0 : cnt + 1'b1;
            if (last_cnt)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;

            // The extra stage lines frame_o up with digit 0's dead cycle on the pins.
            wrap_q  <= boundary;
            frame_q <= wrap_q;

            an_q  <= (cnt == '0) ? '1 : ~(DIGITS'(1) << idx);
            seg_q <= dark ? 8'hFF : {~sh_point[idx], glyph(sh_data[idx])};

            if (bus.load && boundary) begin
                sh_data  <= bus.hex_data;
                sh_point <= bus.point;
                sh_blank <= bus.blank;
                pending  <= 1'b0;
            end else if (bus.load) begin
                pend_data  <= bus.hex_data;
                pend_point <= bus.point;
                pend_blank <= bus.blank;
                pending    <= 1'b1;
            end else if (boundary && pending) begin
                sh_data  <= pend_data;
                sh_point <= pend_point;
                sh_blank <= pend_blank;
                pending  <= 1'b0;
            end
        end
    end

    assign bus.pending_o = pending;
    assign bus.frame_o   = frame_q;
    assign bus.seg_o     = seg_q;
    assign bus.an_o      = an_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=4): vector table, directed
// corner sequences and randomized traffic against a frame-position model.
module tb_seg7_scan_driver;
    localparam int D  = 4;
    localparam int S  = 4;
    localparam int FS = D * S;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_if #(.DIGITS(D)) bus();
    seg7_scan_driver #(.DIGITS(D), .SCAN_DIV(S)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  point;
        logic [3:0]  blank;
    } disp_t;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } vec_t;

    logic [6:0] glyph_tab [16];
    disp_t      m_shadow, m_pend;
    bit         m_pending;
    int         m_n;
    logic [7:0] e_seg;
    logic [3:0] e_an;
    bit         e_frame, e_pend;

    logic [7:0] obs_seg [D];
    bit         obs_ok  [D];
    logic [7:0] watch_val = 8'h00;
    int         watch_hits = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_seg(input disp_t f, input int d);
        bit sup;
        sup = 1'b0;
`ifdef SEG7_LZ_SUPPRESS_EN
        sup = (d != 0);
        for (int j = D - 1; j >= d; j--)
            if (f.data[4*j +: 4] != 4'h0 || f.point[j]) sup = 1'b0;
`endif
        if (f.blank[d] || sup) return 8'hFF;
        return {~f.point[d], glyph_tab[f.data[4*d +: 4]]};
    endfunction

    // Display position is derived from the number of edges since reset release.
    task automatic model_edge();
        disp_t cur;
        int    pos;
        if (rst) begin
            m_n       = 0;
            m_pending = 1'b0;
            m_shadow  = '{16'h0, 4'h0, 4'hF};
            e_seg     = 8'hFF;
            e_an      = 4'hF;
            e_frame   = 1'b0;
            e_pend    = 1'b0;
        end else begin
            m_n++;
            pos     = (m_n - 1) % FS;
            e_an    = (pos % S == 0) ? 4'hF : ~(4'b0001 << (pos / S));
            e_seg   = ref_seg(m_shadow, pos / S);
            e_frame = (m_n > FS) && (pos == 0);
            cur     = '{bus.hex_data, bus.point, bus.blank};
            if (bus.load && pos == FS - 1) begin
                m_shadow  = cur;
                m_pending = 1'b0;
            end else if (bus.load) begin
                m_pend    = cur;
                m_pending = 1'b1;
            end else if (pos == FS - 1 && m_pending) begin
                m_shadow  = m_pend;
                m_pending = 1'b0;
            end
            e_pend = m_pending;
        end
    endtask

    task automatic step();
        logic [3:0] sel;
        @(posedge clk);
        model_edge();
        #2;
        check("m_seg", bus.seg_o, e_seg);
        check("m_an", bus.an_o, e_an);
        check("m_frame", bus.frame_o, e_frame);
        check("m_pend", bus.pending_o, e_pend);
        for (int k = 0; k < D; k++) begin
            sel = ~(4'b0001 << k);
            if (bus.an_o == sel) begin
                obs_seg[k] = bus.seg_o;
                obs_ok[k]  = 1'b1;
            end
        end
        if (bus.an_o != 4'hF && bus.seg_o == watch_val) watch_hits++;
    endtask

    task automatic wait_frame(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * FS && !seen; i++) begin
            step();
            if (bus.frame_o) seen = 1'b1;
        end
        check(nm, seen, 1);
    endtask

    task automatic goto_pos(input int r);
        for (int i = 0; i < FS && (m_n % FS) != r; i++) step();
    endtask

    task automatic collect_frame();
        for (int k = 0; k < D; k++) obs_ok[k] = 1'b0;
        for (int i = 0; i < FS; i++) step();
    endtask

    task automatic check_digits(input string nm, input logic [7:0] e3, input logic [7:0] e2,
                                input logic [7:0] e1, input logic [7:0] e0);
        logic [7:0] ev [D];
        ev = '{e0, e1, e2, e3};
        for (int k = 0; k < D; k++) begin
            check({nm, "_seen"}, obs_ok[k], 1);
            check(nm, obs_seg[k], ev[k]);
        end
    endtask

    task automatic drive_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        bus.load = 1'b1; bus.hex_data = d; bus.point = p; bus.blank = b;
        step();
        bus.load = 1'b0;
    endtask

    vec_t idle_tab [8];
    int   pend_hi;

    initial begin
        glyph_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        idle_tab = '{'{4'hF, 8'hFF}, '{4'hE, 8'hFF}, '{4'hE, 8'hFF}, '{4'hE, 8'hFF},
                     '{4'hF, 8'hFF}, '{4'hD, 8'hFF}, '{4'hD, 8'hFF}, '{4'hD, 8'hFF}};
        for (int k = 0; k < D; k++) begin obs_seg[k] = 8'h00; obs_ok[k] = 1'b0; end

        rst = 1'b1; bus.load = 1'b0; bus.hex_data = '0; bus.point = '0; bus.blank = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_seg", bus.seg_o, 8'hFF);
            check("rst_an", bus.an_o, 4'hF);
            check("rst_pend", bus.pending_o, 0);
            check("rst_frame", bus.frame_o, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("idle_an", bus.an_o, idle_tab[i].an);
            check("idle_seg", bus.seg_o, idle_tab[i].seg);
        end

        // Basic load, displayed after the next frame boundary.
        drive_load(16'h8F10, 4'b0010, 4'b0000);
        check("load_pend", bus.pending_o, 1);
        wait_frame("load_frame");
        check("load_pend_clr", bus.pending_o, 0);
        collect_frame();
        check_digits("load_dig", 8'h80, 8'h8E, 8'h79, 8'hC0);

        // Two loads before a boundary: only the second one reaches the pins.
        goto_pos(2);
        watch_val = 8'hF9; watch_hits = 0;
        drive_load(16'h1111, 4'h0, 4'h0);
        drive_load(16'h2222, 4'h0, 4'h0);
        wait_frame("dbl_frame");
        collect_frame();
        check_digits("dbl_dig", 8'hA4, 8'hA4, 8'hA4, 8'hA4);
        check("dbl_no_1111", watch_hits, 0);
        watch_val = 8'h00;

        // Load exactly on the boundary edge bypasses the pending stage.
        goto_pos(FS - 1);
        pend_hi = 0;
        drive_load(16'h3456, 4'h0, 4'h0);
        if (bus.pending_o) pend_hi++;
        step();
        check("bnd_frame", bus.frame_o, 1);
        for (int k = 0; k < D; k++) obs_ok[k] = 1'b0;
        for (int i = 0; i < FS - 1; i++) begin
            step();
            if (bus.pending_o) pend_hi++;
        end
        check("bnd_pend_never", pend_hi, 0);
        check_digits("bnd_dig", 8'hB0, 8'h99, 8'h92, 8'h82);

        // Reset while data is pending: pending is dropped, display blanks.
        goto_pos(5);
        drive_load(16'h7777, 4'h0, 4'h0);
        check("rp_pend", bus.pending_o, 1);
        step(); step();
        rst = 1'b1;
        step(); step();
        check("rp_rst_an", bus.an_o, 4'hF);
        rst = 1'b0;
        step();
        check("rp_dead_an", bus.an_o, 4'hF);
        check("rp_pend0", bus.pending_o, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rp_an_d0", bus.an_o, 4'hE);
            check("rp_blank", bus.seg_o, 8'hFF);
        end

`ifdef SEG7_LZ_SUPPRESS_EN
        goto_pos(3);
        drive_load(16'h0050, 4'b0000, 4'b0000);
        wait_frame("lz_frame");
        collect_frame();
        check_digits("lz_dig", 8'hFF, 8'hFF, 8'h92, 8'hC0);
        goto_pos(3);
        drive_load(16'h0050, 4'b1000, 4'b0000);
        wait_frame("lzp_frame");
        collect_frame();
        check_digits("lzp_dig", 8'h40, 8'hC0, 8'h92, 8'hC0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.load     = ($urandom_range(0, 5) == 0);
            bus.hex_data = 16'($urandom);
            bus.point    = 4'($urandom);
            bus.blank    = 4'($urandom) & 4'($urandom);
            rst          = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; bus.load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
